// File: rtl/uart_mem_pkg.sv
// rtl/uart_mem_pkg.sv - shared opcodes, response codes and state encodings for the UART memory model
package uart_mem_pkg;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] RSP_ACK  = 8'hA5;
    localparam logic [7:0] RSP_ERR  = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_EXEC,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_phase_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/uart_mem_phy.sv
// rtl/uart_mem_phy.sv - 8N1 byte receiver with framing check and back-to-back byte transmitter
module uart_mem_phy
    import uart_mem_pkg::*;
#(
    parameter int CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_tdata,
    output logic       rx_tvalid,
    output logic       rx_frame_err,
    output logic       rx_busy,
    input  logic [7:0] tx_tdata,
    input  logic       tx_tvalid,
    output logic       tx_tready
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    rx_phase_t       rx_phase;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bitn;
    logic [7:0]      rx_shreg;

    logic            tx_active;
    logic [9:0]      tx_shreg;
    logic [CW-1:0]   tx_cnt;
    logic [3:0]      tx_bitn;
    logic            tx_last;

    // rx_prev gives edge detection so a line held low after a bad stop bit cannot retrigger
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_prev      <= 1'b1;
            rx_phase     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bitn      <= '0;
            rx_shreg     <= '0;
            rx_tdata     <= '0;
            rx_tvalid    <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_meta      <= rx;
            rx_sync      <= rx_meta;
            rx_prev      <= rx_sync;
            rx_tvalid    <= 1'b0;
            rx_frame_err <= 1'b0;
            case (rx_phase)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_phase <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt  <= '0;
                        rx_bitn <= '0;
                        rx_phase <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rx_sync, rx_shreg[7:1]};
                        if (rx_bitn == 3'd7) begin
                            rx_phase <= RX_STOP;
                        end else begin
                            rx_bitn <= rx_bitn + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_phase <= RX_IDLE;
                        if (rx_sync) begin
                            rx_tvalid <= 1'b1;
                            rx_tdata  <= rx_shreg;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_phase <= RX_IDLE;
            endcase
        end
    end

    assign rx_busy = (rx_phase != RX_IDLE);

    // Ready during the final stop-bit cycle lets the next byte start with no idle gap
    assign tx_last   = tx_active && (tx_bitn == 4'd9) && (tx_cnt == BIT_LAST);
    assign tx_tready = !tx_active || tx_last;
    assign tx        = tx_active ? tx_shreg[0] : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_active <= 1'b0;
            tx_shreg  <= '1;
            tx_cnt    <= '0;
            tx_bitn   <= '0;
        end else if (tx_tvalid && tx_tready) begin
            tx_active <= 1'b1;
            tx_shreg  <= {1'b1, tx_tdata, 1'b0};
            tx_cnt    <= '0;
            tx_bitn   <= '0;
        end else if (tx_active) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt   <= '0;
                tx_shreg <= {1'b1, tx_shreg[9:1]};
                if (tx_bitn == 4'd9) begin
                    tx_active <= 1'b0;
                end else begin
                    tx_bitn <= tx_bitn + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_mem_model.sv
// rtl/uart_mem_model.sv - UART-attached word memory: command FSM, address/data assembly, array and error count
module uart_mem_model
    import uart_mem_pkg::*;
#(
    parameter int CLK_PER_BIT  = 16,
    parameter int ADDR_BYTES   = 4,
    parameter int DATA_BYTES   = 4,
    parameter int DEPTH_LOG2   = 10,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Rx,
    output logic        Tx,
    output logic        busy,
    output logic [15:0] err_count
);

    localparam int ADDR_W    = ADDR_BYTES * 8;
    localparam int DATA_W    = DATA_BYTES * 8;
    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam int TO_CYCLES = TIMEOUT_BITS * CLK_PER_BIT;
    localparam int TW        = $clog2(TO_CYCLES + 1);

    state_t              state;
    state_t              state_n;

    logic [7:0]          rx_tdata;
    logic                rx_tvalid;
    logic                rx_frame_err;
    logic                rx_busy;
    logic [7:0]          tx_tdata;
    logic                tx_tvalid;
    logic                tx_tready;

    logic                is_write;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   data_reg;
    logic [3:0]          byte_cnt;
    logic [DATA_W-1:0]   resp_word;
    logic [3:0]          resp_left;
    logic [TW-1:0]       timer;
    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic [DEPTH_LOG2-1:0] idx;
    logic                in_range;
    logic                op_ok;
    logic                rx_live;
    logic                assembling;
    logic                timeout;
    logic                last_addr;
    logic                last_data;
    logic                err_inc;
    logic [DATA_W-1:0]   exec_word;

    uart_mem_phy #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_phy (
        .clk         (CLK),
        .rst         (RST),
        .rx          (Rx),
        .tx          (Tx),
        .rx_tdata    (rx_tdata),
        .rx_tvalid   (rx_tvalid),
        .rx_frame_err(rx_frame_err),
        .rx_busy     (rx_busy),
        .tx_tdata    (tx_tdata),
        .tx_tvalid   (tx_tvalid),
        .tx_tready   (tx_tready)
    );

    assign idx        = DEPTH_LOG2'(addr_reg);
    assign in_range   = ((addr_reg >> DEPTH_LOG2) == '0);
    assign op_ok      = (rx_tdata == OP_READ) || (rx_tdata == OP_WRITE);
    assign assembling = (state == S_ADDR) || (state == S_DATA);
    assign rx_live    = (state == S_IDLE) || assembling;
    assign timeout    = assembling && (timer == TW'(TO_CYCLES));
    assign last_addr  = (byte_cnt == 4'(ADDR_BYTES - 1));
    assign last_data  = (byte_cnt == 4'(DATA_BYTES - 1));

    // The first response byte is handed to the transmitter during EXEC itself
    always_comb begin
        exec_word = '0;
        if (is_write) begin
            exec_word = in_range ? DATA_W'(RSP_ACK) : DATA_W'(RSP_ERR);
        end else if (in_range) begin
            exec_word = mem[idx];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (rx_tvalid) begin
                    state_n = op_ok ? S_ADDR : S_RESP;
                end
            end
            S_ADDR: begin
                if (rx_frame_err || timeout) begin
                    state_n = S_IDLE;
                end else if (rx_tvalid && last_addr) begin
                    state_n = is_write ? S_DATA : S_EXEC;
                end
            end
            S_DATA: begin
                if (rx_frame_err || timeout) begin
                    state_n = S_IDLE;
                end else if (rx_tvalid && last_data) begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: state_n = S_RESP;
            S_RESP: begin
                if ((resp_left == 4'd0) && tx_tready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        tx_tvalid = 1'b0;
        tx_tdata  = 8'h00;
        busy      = (state != S_IDLE);
        err_inc   = 1'b0;
        if (rx_live && rx_frame_err) begin
            err_inc = 1'b1;
        end
        if (timeout) begin
            err_inc = 1'b1;
        end
        if ((state == S_IDLE) && rx_tvalid && !op_ok) begin
            err_inc = 1'b1;
        end
        if ((state == S_EXEC) && !in_range) begin
            err_inc = 1'b1;
        end
        if (state == S_EXEC) begin
            tx_tvalid = 1'b1;
            tx_tdata  = exec_word[7:0];
        end else if (state == S_RESP) begin
            tx_tvalid = (resp_left != 4'd0);
            tx_tdata  = resp_word[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            is_write  <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
            byte_cnt  <= '0;
            resp_word <= '0;
            resp_left <= '0;
            timer     <= '0;
            err_count <= '0;
        end else begin
            if (err_inc) begin
                err_count <= sat_inc16(err_count);
            end
            // Gap timer only runs while the receiver sits between frames
            if (assembling && !rx_busy) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
            case (state)
                S_IDLE: begin
                    byte_cnt <= '0;
                    if (rx_tvalid) begin
                        is_write <= (rx_tdata == OP_WRITE);
                        if (!op_ok) begin
                            resp_word <= DATA_W'(RSP_ERR);
                            resp_left <= 4'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_tvalid) begin
                        addr_reg <= (addr_reg >> 8) | (ADDR_W'(rx_tdata) << (ADDR_W - 8));
                        byte_cnt <= last_addr ? 4'd0 : byte_cnt + 4'd1;
                    end
                end
                S_DATA: begin
                    if (rx_tvalid) begin
                        data_reg <= (data_reg >> 8) | (DATA_W'(rx_tdata) << (DATA_W - 8));
                        byte_cnt <= last_data ? 4'd0 : byte_cnt + 4'd1;
                    end
                end
                S_EXEC: begin
                    resp_word <= exec_word >> 8;
                    resp_left <= is_write ? 4'd0 : 4'(DATA_BYTES - 1);
                end
                S_RESP: begin
                    if (tx_tvalid && tx_tready) begin
                        resp_word <= resp_word >> 8;
                        resp_left <= resp_left - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array contents deliberately survive RST
    always_ff @(posedge CLK) begin
        if (!RST && (state == S_EXEC) && is_write && in_range) begin
            mem[idx] <= data_reg;
        end
    end

endmodule

// File: tb/tb_uart_mem_model.sv
// tb/tb_uart_mem_model.sv - self-checking bench for uart_mem_model
module tb_uart_mem_model;

    localparam int CPB = 16;

    typedef struct {
        logic [71:0] cmd;
        int          ncmd;
        logic [31:0] rsp;
        int          nrsp;
        logic [15:0] err;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Rx;
    logic        Tx;
    logic        busy;
    logic [15:0] err_count;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q[$];
    bit          mon_en = 1'b0;
    bit          mon_ignore = 1'b0;
    int          mon_count = 0;

    always #5 CLK = ~CLK;

    uart_mem_model #(
        .CLK_PER_BIT (CPB),
        .ADDR_BYTES  (4),
        .DATA_BYTES  (4),
        .DEPTH_LOG2  (10),
        .TIMEOUT_BITS(64)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Rx       (Rx),
        .Tx       (Tx),
        .busy     (busy),
        .err_count(err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        Rx = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            repeat (CPB) @(negedge CLK);
        end
        Rx = stop;
        repeat (CPB) @(negedge CLK);
        Rx = 1'b1;
    endtask

    task automatic send_cmd(input logic [71:0] cmd, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(cmd[8*i +: 8], 1'b1);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        check(name, {31'h0, busy}, 32'h0);
        repeat (4) @(negedge CLK);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        for (int i = 0; i < v.nrsp; i++) begin
            exp_q.push_back(v.rsp[8*i +: 8]);
        end
        send_cmd(v.cmd, v.ncmd);
        wait_idle({name, "_busy"});
        check({name, "_missing_bytes"}, exp_q.size(), 32'h0);
        exp_q.delete();
        check({name, "_err_count"}, {16'h0, err_count}, {16'h0, v.err});
        check({name, "_tx_idle"}, {31'h0, Tx}, 32'h1);
    endtask

    // Serial receiver on Tx: decodes each frame and pops the scoreboard
    initial begin : monitor
        logic [7:0] b;
        logic       startb;
        logic       stopb;
        wait (mon_en);
        forever begin
            @(negedge Tx);
            repeat (CPB / 2) @(posedge CLK);
            #1 startb = Tx;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge CLK);
                #1 b[i] = Tx;
            end
            repeat (CPB) @(posedge CLK);
            #1 stopb = Tx;
            if (!mon_ignore) begin
                mon_count++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_tx_byte: got %h expected none", b);
                end else begin
                    check("tx_frame", {22'h0, startb, stopb, b}, {22'h0, 1'b0, 1'b1, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge CLK);
        $display("FAIL watchdog: simulation did not complete within cycle budget");
        $fatal(1);
    end

    initial begin : stim
        vec_t vecs[9];
        vec_t rd5;
        int   tx_bad;
        int   start_cnt;
        int   n;

        vecs[0] = '{cmd: {32'hDEADBEEF, 32'h0000_0005, 8'h02}, ncmd: 9, rsp: 32'h0000_00A5, nrsp: 1, err: 16'd0};
        vecs[1] = '{cmd: {32'h0,        32'h0000_0005, 8'h01}, ncmd: 5, rsp: 32'hDEADBEEF, nrsp: 4, err: 16'd0};
        vecs[2] = '{cmd: {32'h11223344, 32'h0000_0000, 8'h02}, ncmd: 9, rsp: 32'h0000_00A5, nrsp: 1, err: 16'd0};
        vecs[3] = '{cmd: {32'h0,        32'h0,         8'h7F}, ncmd: 1, rsp: 32'h0000_00EE, nrsp: 1, err: 16'd1};
        vecs[4] = '{cmd: {32'h0,        32'h0000_0005, 8'h01}, ncmd: 5, rsp: 32'hDEADBEEF, nrsp: 4, err: 16'd1};
        vecs[5] = '{cmd: {32'hCAFEF00D, 32'h0000_0400, 8'h02}, ncmd: 9, rsp: 32'h0000_00EE, nrsp: 1, err: 16'd2};
        vecs[6] = '{cmd: {32'h0,        32'h0000_0400, 8'h01}, ncmd: 5, rsp: 32'h0000_0000, nrsp: 4, err: 16'd3};
        vecs[7] = '{cmd: {32'h0,        32'h0000_0000, 8'h01}, ncmd: 5, rsp: 32'h11223344, nrsp: 4, err: 16'd3};
        vecs[8] = '{cmd: {32'h0000_0055, 32'h0100_0000, 8'h02}, ncmd: 9, rsp: 32'h0000_00EE, nrsp: 1, err: 16'd4};
        rd5     = '{cmd: {32'h0,        32'h0000_0005, 8'h01}, ncmd: 5, rsp: 32'hDEADBEEF, nrsp: 4, err: 16'd0};

        RST = 1'b1;
        Rx  = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_tx", {31'h0, Tx}, 32'h1);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_err_count", {16'h0, err_count}, 32'h0);
        RST = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge CLK);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Bad stop bit on the second address byte
        send_byte(8'h01, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (20) @(negedge CLK);
        check("frame_busy", {31'h0, busy}, 32'h0);
        check("frame_err_count", {16'h0, err_count}, 32'd5);
        check("frame_tx_idle", {31'h0, Tx}, 32'h1);
        rd5.err = 16'd5;
        run_vec(rd5, "after_frame_read");

        // Truncated WRITE left to time out
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        tx_bad = 0;
        for (int i = 0; i < 900; i++) begin
            @(negedge CLK);
            if (Tx !== 1'b1) tx_bad++;
        end
        check("timeout_busy_before", {31'h0, busy}, 32'h1);
        for (int i = 0; i < 250; i++) begin
            @(negedge CLK);
            if (Tx !== 1'b1) tx_bad++;
        end
        check("timeout_busy_after", {31'h0, busy}, 32'h0);
        check("timeout_err_count", {16'h0, err_count}, 32'd6);
        check("timeout_tx_quiet", tx_bad, 32'h0);

        // RST in the middle of the second READ response byte
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(rd5.rsp[8*i +: 8]);
        end
        start_cnt = mon_count;
        send_cmd(rd5.cmd, rd5.ncmd);
        n = 0;
        while (mon_count == start_cnt && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("rst_first_byte_seen", mon_count - start_cnt, 32'h1);
        repeat (60) @(negedge CLK);
        mon_ignore = 1'b1;
        exp_q.delete();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_mid_tx", {31'h0, Tx}, 32'h1);
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        check("rst_mid_err_count", {16'h0, err_count}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (300) @(negedge CLK);
        check("rst_line_idle", {31'h0, Tx}, 32'h1);
        mon_ignore = 1'b0;
        rd5.err = 16'd0;
        run_vec(rd5, "after_reset_read");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_mem_model.md
Name: uart_mem_model

Overview:
- Parametrised UART-attached memory model; the successor to the team's simulation memory that sits on the CPU's serial link.
- Receives 8N1 command frames on Rx and executes word reads/writes against an internal array.
- Returns response bytes on Tx.
- Address width, data width, depth, baud divisor and inter-byte timeout are generic, so the same model serves 16/32/64-bit CPU variants in bench and on FPGA.

Parameters:
CLK_PER_BIT, 16, clock cycles per UART bit (min 4)
ADDR_BYTES, 4, address bytes per command (1..4)
DATA_BYTES, 4, data bytes per word (1..8)
DEPTH_LOG2, 10, log2 of word count in array
TIMEOUT_BITS, 64, bit-times allowed between bytes of one command before abort

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
Rx  in  1  serial input, idle high (from CPU Tx)
Tx  out  1  serial output, idle high (to CPU Rx)
busy  out  1  high from first opcode byte until last response stop bit ends
err_count  out  16  saturating count of framing errors, timeouts and bad commands

Behaviour:
- Reset values: Tx=1, busy=0, err_count=0, FSM=IDLE, rx/tx shifters cleared. Memory contents are NOT cleared by RST.
- RST is synchronous and active-high, and honoured in any state. Reset mid-frame aborts the frame with no response; Tx is 1 on the cycle after RST is sampled.
- Rx path:
  - 2-flop synchroniser.
  - Start is a falling edge; it is confirmed at CLK_PER_BIT/2, and a high sample there means a glitch: drop it.
  - 8 data bits LSB-first, each sampled at bit centre.
  - Stop sample 0 = framing error: discard the byte, err_count+1, FSM to IDLE.
- Tx path: 8N1, LSB-first; one byte per 10*CLK_PER_BIT cycles, back-to-back with no gap.
- Command format:
  - opcode byte: 0x01 READ, 0x02 WRITE.
  - Then ADDR_BYTES address bytes, little-endian.
  - WRITE only: then DATA_BYTES data bytes, little-endian.
- Address is a word index. idx = addr[DEPTH_LOG2-1:0]. It is in range iff all higher address bits are 0.
- FSM states: IDLE -> ADDR -> (WRITE: DATA) -> EXEC -> RESP -> IDLE.
  - IDLE: unknown opcode -> queue response 0xEE, err_count+1, go to RESP.
  - EXEC lasts exactly 1 cycle. WRITE in range: array[idx] updated in EXEC.
  - Responses:
    - READ in range: DATA_BYTES bytes of array[idx], LE.
    - READ out of range: DATA_BYTES bytes of 0x00, err_count+1.
    - WRITE in range: single 0xA5.
    - WRITE out of range: single 0xEE, err_count+1, no write.
  - First response start bit begins 1 cycle after EXEC.
- Timeout: in ADDR/DATA, a counter runs from each stop bit. If TIMEOUT_BITS*CLK_PER_BIT cycles pass with no new start bit: abort to IDLE, no response, err_count+1.
- Rx bytes arriving during RESP are dropped; no overlap, single outstanding command.
- err_count saturates at 0xFFFF. Simultaneous error sources in one cycle add 1.
- busy falls the cycle the last response stop bit completes. It falls on abort immediately.

Decomposition:
- Package uart_mem_pkg holds:
  - Opcode constants OP_READ=8'h01, OP_WRITE=8'h02.
  - Response constants RSP_ACK=8'hA5, RSP_ERR=8'hEE.
  - The FSM state enum.
- One sub-module, uart_mem_phy: byte-level rx (synchroniser, sampling, framing check) plus tx shifter, with a valid/ready byte interface. The top holds the FSM, assembly registers, array and counters.

Test Plan:
- CLK_PER_BIT=16, defaults. WRITE addr 0x00000005 data 0xDEADBEEF, then READ addr 5 -> ack 0xA5, then Tx bytes EF BE AD DE; err_count=0.
- Opcode 0x7F -> Tx 0xEE, err_count=1, busy low after the one response byte; a following valid READ still works.
- Byte with stop bit driven 0 mid-address -> no response, err_count+1, FSM IDLE; the next full command succeeds.
- WRITE addr 0x00000400 (DEPTH_LOG2=10) -> 0xEE, array unchanged. READ addr 0x400 -> 00 00 00 00.
- Opcode + 2 address bytes, then idle 64*16 cycles -> abort, err_count+1, busy=0, Tx stays 1.
- RST pulsed during READ response byte 2 -> Tx=1 next cycle, busy=0, err_count=0; a re-READ returns the previously written data, confirming memory retained.
